pipe_ctrl_unit: RTL and testbench
=================================

Name: pipe_ctrl_unit

Overview:
- Control unit for the 5-stage pipelined MIPS core.
- Decodes the D-stage instruction once into a control word and carries that word through E/M/W pipeline registers.
- Tracks per-stage result-ready time (Tnew) and requested-use time (Tuse) to drive the stall decision.
- Inserts E-stage bubbles on stall. Supersedes per-stage re-decoding.
- Instruction set: beq, blez, j, jal, jalr, jr, lb, lbu, lh, lhu, lw, sb, sh, sw, lui, ori, slti, addu, subu, and, or, sll, sllv, slt.

Parameters:
- REG_AW, 5, register-address width for rs/rt/rd/A3 fields and outputs.
- TNEW_LOAD, 2, E-stage Tnew of load instructions.
- TNEW_ALU, 1, E-stage Tnew of ALU-result instructions (R-type ALU, ori, lui, slti).
- HAZARD_EN, 1, 1 = stall logic active; 0 = stall forced 0 (forwarding-only bring-up mode).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- D_instr  in  32  instruction in D stage.
- ext_flush  in  1  clears the E register to a bubble (e.g. exception or redirect), independent of stall.
- stall  out  1  high = hold PC and the F/D register; E receives a bubble.
- D_Br  out  3  branch/jump select for the D-stage NPC logic.
- D_EXTOp  out  1  sign-extend select for the D-stage immediate.
- E_ALUControl  out  4  ALU operation.
- E_ALUBSelImm  out  1  ALU B operand = immediate.
- E_A3  out  REG_AW  destination register in E.
- E_Tnew  out  2  cycles until the E result is available.
- M_DMWr  out  1  data-memory write enable.
- M_DMType  out  3  access width/sign.
- M_A3  out  REG_AW  destination register in M.
- M_Tnew  out  2  cycles until the M result is available.
- W_RFWr  out  1  register-file write enable.
- W_WDSel  out  3  write-data source.
- W_A3  out  REG_AW  destination register in W.

Behaviour:
- Decode (combinational from D_instr):
  - A3 = rd for R-type arithmetic/logic and jalr; 31 for jal; rt for loads, ori, lui, slti; 0 for stores, branches, j, jr.
  - A3 = 0 means no write: RFWr is derived as (A3 != 0).
  - Unknown opcode/funct decodes to an all-zero control word (nop).
- Tuse:
  - rs_Tuse = 0 for beq, blez, jr, jalr; 1 for ALU/load/store base.
  - rt_Tuse = 0 for beq; 1 for R-type ALU incl. sll/sllv; 2 for stores.
  - Unused operand: Tuse = 3 (never stalls).
- Tnew at E entry: TNEW_LOAD for loads; TNEW_ALU for ALU results; 0 for jal/jalr (PC+8 known early); 0 for no-write instructions.
- Pipeline registers update every rising clk edge:
  - M <- E, with M_Tnew = sat(E_Tnew-1), saturating at 0.
  - W <- M; W Tnew is always 0.
- Stall condition, when HAZARD_EN=1: any of the following holds for rs or rt, with addr != 0:
  - (addr == E_A3) and Tuse < E_Tnew;
  - (addr == M_A3) and Tuse < M_Tnew.
- stall is combinational, same cycle. When stall = 1, the E register loads a bubble (all-zero word, A3=0, Tnew=0); D_* outputs continue to reflect the held D_instr.
- ext_flush=1 loads a bubble into E regardless of stall. stall and ext_flush together: bubble (same result). M and W are never stalled.
- Reset: all E/M/W registers become bubbles on the reset edge. After reset, every E_/M_/W_ output = 0 and stall = 0 until a dependent instruction appears.
- Reset mid-stall: the stall condition is cleared on the next cycle because E and M are empty.
- Encodings for ALUControl, Br, WDSel, DMType: values are those of the shared control package.

Decomposition:
- Package ctrl_defs holds:
  - opcode and funct constants;
  - ALU_*, BR_*, WDSel_*, DM_* encodings;
  - TUSE_NONE = 3;
  - control-word struct {ALUControl, ALUBSelImm, DMWr, DMType, WDSel, A3, Tnew}.
- Sub-module instr_decoder: purely combinational, D_instr -> control word + rs/rt Tuse + Br/EXTOp. It is instantiated once.
- pipe_ctrl_unit holds the stage registers, the Tnew countdown and the stall comparator.

Test Plan:
- lw $1,0($0) then addu $2,$1,$1 → stall=1 for exactly 1 cycle (E_Tnew=2 vs Tuse=1, then M_Tnew=1 vs 1 clears). One bubble seen in E (E_A3=0). W_A3=1 with W_WDSel=DMout, then W_A3=2 with ALUout.
- ori $3,$0,5 then beq $3,$0 → stall=1 for 1 cycle (E_Tnew=1, Tuse=0), then released when ori reaches M with M_Tnew=0.
- jal then jr $31 → no stall (Tnew=0). E_A3=31, W_WDSel=PC4 three cycles after jal is decoded.
- sw $4,0($5) after lw $4 → rt_Tuse=2 ≥ 2, no stall. M_DMWr=1, M_DMType=DM_w. W_RFWr=0 for the sw.
- Dependency on $0 (lw $0 then addu $2,$0,$0) → stall=0. HAZARD_EN=0 build: lw/use pair → stall stays 0.
- reset asserted while stall=1 → next cycle all E/M/W outputs are 0 and stall=0. ext_flush during a stall → E bubble, D held.

Source files
------------

// File: rtl/ctrl_defs_pkg.sv
// Shared control encodings, MIPS opcode/funct constants and the pipelined control word.
package ctrl_defs;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03, OP_BEQ  = 6'h04,
                         OP_BLEZ  = 6'h06, OP_SLTI = 6'h0a, OP_ORI  = 6'h0d, OP_LUI  = 6'h0f,
                         OP_LB    = 6'h20, OP_LH   = 6'h21, OP_LW   = 6'h23, OP_LBU  = 6'h24,
                         OP_LHU   = 6'h25, OP_SB   = 6'h28, OP_SH   = 6'h29, OP_SW   = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00, FN_SLLV = 6'h04, FN_JR  = 6'h08, FN_JALR = 6'h09,
                         FN_ADDU = 6'h21, FN_SUBU = 6'h23, FN_AND = 6'h24, FN_OR   = 6'h25,
                         FN_SLT  = 6'h2a;

  localparam logic [3:0] ALU_NONE = 4'd0, ALU_ADD = 4'd1, ALU_SUB = 4'd2, ALU_AND = 4'd3,
                         ALU_OR   = 4'd4, ALU_SLL = 4'd5, ALU_SLLV = 4'd6, ALU_SLT = 4'd7,
                         ALU_LUI  = 4'd8;

  localparam logic [2:0] BR_PC4 = 3'd0, BR_BEQ = 3'd1, BR_BLEZ = 3'd2, BR_J = 3'd3, BR_JR = 3'd4;

  localparam logic [2:0] WDSEL_NONE = 3'd0, WDSEL_ALU = 3'd1, WDSEL_DM = 3'd2, WDSEL_PC4 = 3'd3;

  localparam logic [2:0] DM_NONE = 3'd0, DM_W = 3'd1, DM_H = 3'd2, DM_HU = 3'd3,
                         DM_B    = 3'd4, DM_BU = 3'd5;

  localparam logic [1:0] TUSE_NONE = 2'd3;
  localparam logic [4:0] REG_RA    = 5'd31;

  typedef struct packed {
    logic [3:0] alu_control;
    logic       alu_b_sel_imm;
    logic       dm_wr;
    logic [2:0] dm_type;
    logic [2:0] wd_sel;
    logic [4:0] a3;
    logic [1:0] tnew;
  } ctrl_word_t;

  // A source register conflicts with a producer that will not have its result in time.
  function automatic logic stage_hazard(input logic [4:0] addr, input logic [1:0] tuse,
                                        input logic [4:0] e_a3, input logic [1:0] e_tnew,
                                        input logic [4:0] m_a3, input logic [1:0] m_tnew);
    return (addr != 5'd0) &&
           (((addr == e_a3) && (tuse < e_tnew)) || ((addr == m_a3) && (tuse < m_tnew)));
  endfunction

endpackage

// File: rtl/pipe_ctrl_unit_decoder.sv
// Single D-stage decoder: instruction -> control word, operand use times and NPC select.
module instr_decoder
  import ctrl_defs::*;
#(
  parameter int TNEW_LOAD = 2,
  parameter int TNEW_ALU  = 1
) (
  input  logic [31:0] instr,
  output ctrl_word_t  cw,
  output logic [1:0]  rs_tuse,
  output logic [1:0]  rt_tuse,
  output logic [2:0]  br,
  output logic        ext_op
);

  logic [5:0] op, funct;
  logic [4:0] rt, rd;

  assign op    = instr[31:26];
  assign funct = instr[5:0];
  assign rt    = instr[20:16];
  assign rd    = instr[15:11];

  always_comb begin
    cw      = '0;
    rs_tuse = TUSE_NONE;
    rt_tuse = TUSE_NONE;
    br      = BR_PC4;
    ext_op  = 1'b0;
    // The all-zero word is the canonical nop; keep it an all-zero control word too.
    if (instr != 32'h0) begin
      case (op)
        OP_RTYPE: begin
          case (funct)
            FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SLT, FN_SLLV: begin
              case (funct)
                FN_ADDU: cw.alu_control = ALU_ADD;
                FN_SUBU: cw.alu_control = ALU_SUB;
                FN_AND:  cw.alu_control = ALU_AND;
                FN_OR:   cw.alu_control = ALU_OR;
                FN_SLT:  cw.alu_control = ALU_SLT;
                default: cw.alu_control = ALU_SLLV;
              endcase
              cw.wd_sel = WDSEL_ALU;
              cw.a3     = rd;
              cw.tnew   = 2'(TNEW_ALU);
              rs_tuse   = 2'd1;
              rt_tuse   = 2'd1;
            end
            FN_SLL: begin
              cw.alu_control = ALU_SLL;
              cw.wd_sel      = WDSEL_ALU;
              cw.a3          = rd;
              cw.tnew        = 2'(TNEW_ALU);
              rt_tuse        = 2'd1;
            end
            FN_JR: begin
              br      = BR_JR;
              rs_tuse = 2'd0;
            end
            FN_JALR: begin
              br        = BR_JR;
              rs_tuse   = 2'd0;
              cw.wd_sel = WDSEL_PC4;
              cw.a3     = rd;
            end
            default: ;
          endcase
        end
        OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW: begin
          cw.alu_control   = ALU_ADD;
          cw.alu_b_sel_imm = 1'b1;
          cw.wd_sel        = WDSEL_DM;
          cw.a3            = rt;
          cw.tnew          = 2'(TNEW_LOAD);
          ext_op           = 1'b1;
          rs_tuse          = 2'd1;
          case (op)
            OP_LB:   cw.dm_type = DM_B;
            OP_LBU:  cw.dm_type = DM_BU;
            OP_LH:   cw.dm_type = DM_H;
            OP_LHU:  cw.dm_type = DM_HU;
            default: cw.dm_type = DM_W;
          endcase
        end
        OP_SB, OP_SH, OP_SW: begin
          cw.alu_control   = ALU_ADD;
          cw.alu_b_sel_imm = 1'b1;
          cw.dm_wr         = 1'b1;
          ext_op           = 1'b1;
          rs_tuse          = 2'd1;
          rt_tuse          = 2'd2;
          case (op)
            OP_SB:   cw.dm_type = DM_B;
            OP_SH:   cw.dm_type = DM_H;
            default: cw.dm_type = DM_W;
          endcase
        end
        OP_BEQ: begin
          br      = BR_BEQ;
          ext_op  = 1'b1;
          rs_tuse = 2'd0;
          rt_tuse = 2'd0;
        end
        OP_BLEZ: begin
          br      = BR_BLEZ;
          ext_op  = 1'b1;
          rs_tuse = 2'd0;
        end
        OP_J: br = BR_J;
        OP_JAL: begin
          br        = BR_J;
          cw.wd_sel = WDSEL_PC4;
          cw.a3     = REG_RA;
        end
        OP_LUI, OP_ORI, OP_SLTI: begin
          cw.alu_control   = (op == OP_LUI) ? ALU_LUI : ((op == OP_ORI) ? ALU_OR : ALU_SLT);
          cw.alu_b_sel_imm = 1'b1;
          cw.wd_sel        = WDSEL_ALU;
          cw.a3            = rt;
          cw.tnew          = 2'(TNEW_ALU);
          ext_op           = (op == OP_SLTI);
          rs_tuse          = (op == OP_LUI) ? TUSE_NONE : 2'd1;
        end
        default: ;
      endcase
      // A write to $0 produces nothing a consumer could wait for.
      if (cw.a3 == 5'd0) cw.tnew = 2'd0;
    end
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control: decode once in D, carry the control word through E/M/W, stall on Tuse/Tnew.
module pipe_ctrl_unit
  import ctrl_defs::*;
#(
  parameter int REG_AW    = 5,
  parameter int TNEW_LOAD = 2,
  parameter int TNEW_ALU  = 1,
  parameter int HAZARD_EN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       D_instr,
  input  logic              ext_flush,
  output logic              stall,
  output logic [2:0]        D_Br,
  output logic              D_EXTOp,
  output logic [3:0]        E_ALUControl,
  output logic              E_ALUBSelImm,
  output logic [REG_AW-1:0] E_A3,
  output logic [1:0]        E_Tnew,
  output logic              M_DMWr,
  output logic [2:0]        M_DMType,
  output logic [REG_AW-1:0] M_A3,
  output logic [1:0]        M_Tnew,
  output logic              W_RFWr,
  output logic [2:0]        W_WDSel,
  output logic [REG_AW-1:0] W_A3
);

  ctrl_word_t d_cw, e_q;
  logic [1:0] rs_tuse, rt_tuse;
  logic [4:0] rs_addr, rt_addr;
  logic       hazard;

  logic [4:0] m_a3_q, w_a3_q;
  logic [1:0] m_tnew_q;
  logic       m_dm_wr_q;
  logic [2:0] m_dm_type_q, m_wd_sel_q, w_wd_sel_q;

  instr_decoder #(
    .TNEW_LOAD (TNEW_LOAD),
    .TNEW_ALU  (TNEW_ALU)
  ) u_dec (
    .instr   (D_instr),
    .cw      (d_cw),
    .rs_tuse (rs_tuse),
    .rt_tuse (rt_tuse),
    .br      (D_Br),
    .ext_op  (D_EXTOp)
  );

  assign rs_addr = D_instr[25:21];
  assign rt_addr = D_instr[20:16];

  assign hazard = stage_hazard(rs_addr, rs_tuse, e_q.a3, e_q.tnew, m_a3_q, m_tnew_q) ||
                  stage_hazard(rt_addr, rt_tuse, e_q.a3, e_q.tnew, m_a3_q, m_tnew_q);
  assign stall  = (HAZARD_EN != 0) ? hazard : 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q         <= '0;
      m_a3_q      <= '0;
      m_tnew_q    <= '0;
      m_dm_wr_q   <= 1'b0;
      m_dm_type_q <= '0;
      m_wd_sel_q  <= '0;
      w_a3_q      <= '0;
      w_wd_sel_q  <= '0;
    end else begin
      e_q         <= (stall || ext_flush) ? '0 : d_cw;
      m_a3_q      <= e_q.a3;
      m_tnew_q    <= (e_q.tnew == 2'd0) ? 2'd0 : e_q.tnew - 2'd1;
      m_dm_wr_q   <= e_q.dm_wr;
      m_dm_type_q <= e_q.dm_type;
      m_wd_sel_q  <= e_q.wd_sel;
      w_a3_q      <= m_a3_q;
      w_wd_sel_q  <= m_wd_sel_q;
    end
  end

  assign E_ALUControl = e_q.alu_control;
  assign E_ALUBSelImm = e_q.alu_b_sel_imm;
  assign E_A3         = REG_AW'(e_q.a3);
  assign E_Tnew       = e_q.tnew;
  assign M_DMWr       = m_dm_wr_q;
  assign M_DMType     = m_dm_type_q;
  assign M_A3         = REG_AW'(m_a3_q);
  assign M_Tnew       = m_tnew_q;
  assign W_RFWr       = (w_a3_q != 5'd0);
  assign W_WDSel      = w_wd_sel_q;
  assign W_A3         = REG_AW'(w_a3_q);

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Scoreboard bench: directed instruction pairs with per-cycle expected control outputs.
module tb_pipe_ctrl_unit;
  import ctrl_defs::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] D_instr;
  logic        ext_flush;

  logic       stall, D_EXTOp, E_ALUBSelImm, M_DMWr, W_RFWr;
  logic [2:0] D_Br, M_DMType, W_WDSel;
  logic [3:0] E_ALUControl;
  logic [4:0] E_A3, M_A3, W_A3;
  logic [1:0] E_Tnew, M_Tnew;

  logic       nh_stall, nh_EXTOp, nh_BSel, nh_DMWr, nh_RFWr;
  logic [2:0] nh_Br, nh_DMType, nh_WDSel;
  logic [3:0] nh_ALU;
  logic [4:0] nh_EA3, nh_MA3, nh_WA3;
  logic [1:0] nh_ETnew, nh_MTnew;

  always #5 clk = ~clk;

  pipe_ctrl_unit dut (
    .clk(clk), .reset(reset), .D_instr(D_instr), .ext_flush(ext_flush),
    .stall(stall), .D_Br(D_Br), .D_EXTOp(D_EXTOp),
    .E_ALUControl(E_ALUControl), .E_ALUBSelImm(E_ALUBSelImm), .E_A3(E_A3), .E_Tnew(E_Tnew),
    .M_DMWr(M_DMWr), .M_DMType(M_DMType), .M_A3(M_A3), .M_Tnew(M_Tnew),
    .W_RFWr(W_RFWr), .W_WDSel(W_WDSel), .W_A3(W_A3)
  );

  pipe_ctrl_unit #(.HAZARD_EN(0)) dut_nh (
    .clk(clk), .reset(reset), .D_instr(D_instr), .ext_flush(ext_flush),
    .stall(nh_stall), .D_Br(nh_Br), .D_EXTOp(nh_EXTOp),
    .E_ALUControl(nh_ALU), .E_ALUBSelImm(nh_BSel), .E_A3(nh_EA3), .E_Tnew(nh_ETnew),
    .M_DMWr(nh_DMWr), .M_DMType(nh_DMType), .M_A3(nh_MA3), .M_Tnew(nh_MTnew),
    .W_RFWr(nh_RFWr), .W_WDSel(nh_WDSel), .W_A3(nh_WA3)
  );

  localparam logic [31:0] I_NOP   = 32'h0000_0000, I_LW1  = 32'h8C01_0000,
                          I_ADDU  = 32'h0021_1021, I_ORI3 = 32'h3403_0005,
                          I_BEQ   = 32'h1060_0001, I_JAL  = 32'h0C00_0010,
                          I_JR31  = 32'h03E0_0008, I_LW4  = 32'h8C04_0000,
                          I_SW    = 32'hACA4_0000, I_LW0  = 32'h8C00_0000,
                          I_ADDU0 = 32'h0000_1021;

  typedef struct packed {
    logic       stall;
    logic [2:0] br;
    logic       ext;
    logic [4:0] e_a3;
    logic [1:0] e_tnew;
    logic [3:0] e_alu;
    logic [4:0] m_a3;
    logic [1:0] m_tnew;
    logic       m_dmwr;
    logic [2:0] m_dmt;
    logic [4:0] w_a3;
    logic       w_rfwr;
    logic [2:0] w_wd;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  function automatic exp_t mk(input logic st, input logic [2:0] br, input logic ext,
                              input logic [4:0] ea3, input logic [1:0] etn, input logic [3:0] ealu,
                              input logic [4:0] ma3, input logic [1:0] mtn, input logic mwr,
                              input logic [2:0] mdt, input logic [4:0] wa3, input logic wrf,
                              input logic [2:0] wwd);
    exp_t e;
    e = '{st, br, ext, ea3, etn, ealu, ma3, mtn, mwr, mdt, wa3, wrf, wwd};
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s cycle %0d: got %0d, expected %0d", nm, cyc, act, req);
  endtask

  task automatic step(input logic [31:0] ins, input logic fl, input logic rs, input exp_t e);
    @(posedge clk);
    #1;
    cyc++;
    D_instr   = ins;
    ext_flush = fl;
    reset     = rs;
    sb_q.push_back(e);
  endtask

  // Monitor: every cycle that has a pending expectation is compared field by field.
  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk("stall",        32'(stall),        32'(e.stall));
      chk("D_Br",         32'(D_Br),         32'(e.br));
      chk("D_EXTOp",      32'(D_EXTOp),      32'(e.ext));
      chk("E_A3",         32'(E_A3),         32'(e.e_a3));
      chk("E_Tnew",       32'(E_Tnew),       32'(e.e_tnew));
      chk("E_ALUControl", 32'(E_ALUControl), 32'(e.e_alu));
      chk("M_A3",         32'(M_A3),         32'(e.m_a3));
      chk("M_Tnew",       32'(M_Tnew),       32'(e.m_tnew));
      chk("M_DMWr",       32'(M_DMWr),       32'(e.m_dmwr));
      chk("M_DMType",     32'(M_DMType),     32'(e.m_dmt));
      chk("W_A3",         32'(W_A3),         32'(e.w_a3));
      chk("W_RFWr",       32'(W_RFWr),       32'(e.w_rfwr));
      chk("W_WDSel",      32'(W_WDSel),      32'(e.w_wd));
      chk("nohaz_stall",  32'(nh_stall),     32'd0);
    end
  end

  initial begin
    reset     = 1'b1;
    D_instr   = I_NOP;
    ext_flush = 1'b0;
    repeat (2) @(posedge clk);

    // lw $1 / addu $2,$1,$1: one load-use stall, one bubble
    step(I_LW1,  0, 0, mk(0, BR_PC4, 1,  0, 0, 0,        0, 0, 0, 0,     0, 0, 0));
    step(I_ADDU, 0, 0, mk(1, BR_PC4, 0,  1, 2, ALU_ADD,  0, 0, 0, 0,     0, 0, 0));
    step(I_ADDU, 0, 0, mk(0, BR_PC4, 0,  0, 0, 0,        1, 1, 0, DM_W,  0, 0, 0));
    step(I_NOP,  0, 0, mk(0, BR_PC4, 0,  2, 1, ALU_ADD,  0, 0, 0, 0,     1, 1, WDSEL_DM));
    step(I_NOP,  0, 0, mk(0, BR_PC4, 0,  0, 0, 0,        2, 0, 0, 0,     0, 0, 0));
    step(I_NOP,  0, 0, mk(0, BR_PC4, 0,  0, 0, 0,        0, 0, 0, 0,     2, 1, WDSEL_ALU));
    // ori $3 / beq $3,$0: branch needs rs in D
    step(I_ORI3, 0, 0, mk(0, BR_PC4, 0,  0, 0, 0,        0, 0, 0, 0,     0, 0, 0));
    step(I_BEQ,  0, 0, mk(1, BR_BEQ, 1,  3, 1, ALU_OR,   0, 0, 0, 0,     0, 0, 0));
    step(I_BEQ,  0, 0, mk(0, BR_BEQ, 1,  0, 0, 0,        3, 0, 0, 0,     0, 0, 0));
    step(I_NOP,  0, 0, mk(0, BR_PC4, 0,  0, 0, 0,        0, 0, 0, 0,     3, 1, WDSEL_ALU));
    step(I_NOP,  0, 0, mk(0, BR_PC4, 0,  0, 0, 0,        0, 0, 0, 0,     0, 0, 0));
    // jal / jr $31: link value is ready immediately
    step(I_JAL,  0, 0, mk(0, BR_J,   0,  0, 0, 0,        0, 0, 0, 0,     0, 0, 0));
    step(I_JR31, 0, 0, mk(0, BR_JR,  0, 31, 0, 0,        0, 0, 0, 0,     0, 0, 0));
    step(I_NOP,  0, 0, mk(0, BR_PC4, 0,  0, 0, 0,       31, 0, 0, 0,     0, 0, 0));
    step(I_NOP,  0, 0, mk(0, BR_PC4, 0,  0, 0, 0,        0, 0, 0, 0,    31, 1, WDSEL_PC4));
    // lw $4 / sw $4,0($5): store data is needed late
    step(I_LW4,  0, 0, mk(0, BR_PC4, 1,  0, 0, 0,        0, 0, 0, 0,     0, 0, 0));
    step(I_SW,   0, 0, mk(0, BR_PC4, 1,  4, 2, ALU_ADD,  0, 0, 0, 0,     0, 0, 0));
    step(I_NOP,  0, 0, mk(0, BR_PC4, 0,  0, 0, ALU_ADD,  4, 1, 0, DM_W,  0, 0, 0));
    step(I_NOP,  0, 0, mk(0, BR_PC4, 0,  0, 0, 0,        0, 0, 1, DM_W,  4, 1, WDSEL_DM));
    step(I_NOP,  0, 0, mk(0, BR_PC4, 0,  0, 0, 0,        0, 0, 0, 0,     0, 0, 0));
    // lw $0 / addu $2,$0,$0: $0 never stalls
    step(I_LW0,  0, 0, mk(0, BR_PC4, 1,  0, 0, 0,        0, 0, 0, 0,     0, 0, 0));
    step(I_ADDU0,0, 0, mk(0, BR_PC4, 0,  0, 0, ALU_ADD,  0, 0, 0, 0,     0, 0, 0));
    step(I_NOP,  0, 0, mk(0, BR_PC4, 0,  2, 1, ALU_ADD,  0, 0, 0, DM_W,  0, 0, 0));
    step(I_NOP,  0, 0, mk(0, BR_PC4, 0,  0, 0, 0,        2, 0, 0, 0,     0, 0, WDSEL_DM));
    step(I_NOP,  0, 0, mk(0, BR_PC4, 0,  0, 0, 0,        0, 0, 0, 0,     2, 1, WDSEL_ALU));
    // reset while stalled
    step(I_LW1,  0, 0, mk(0, BR_PC4, 1,  0, 0, 0,        0, 0, 0, 0,     0, 0, 0));
    step(I_ADDU, 0, 1, mk(1, BR_PC4, 0,  1, 2, ALU_ADD,  0, 0, 0, 0,     0, 0, 0));
    step(I_ADDU, 0, 0, mk(0, BR_PC4, 0,  0, 0, 0,        0, 0, 0, 0,     0, 0, 0));
    step(I_NOP,  0, 0, mk(0, BR_PC4, 0,  2, 1, ALU_ADD,  0, 0, 0, 0,     0, 0, 0));
    step(I_NOP,  0, 0, mk(0, BR_PC4, 0,  0, 0, 0,        2, 0, 0, 0,     0, 0, 0));
    step(I_NOP,  0, 0, mk(0, BR_PC4, 0,  0, 0, 0,        0, 0, 0, 0,     2, 1, WDSEL_ALU));
    // ext_flush during a stall, then ext_flush alone squashing ori
    step(I_LW1,  0, 0, mk(0, BR_PC4, 1,  0, 0, 0,        0, 0, 0, 0,     0, 0, 0));
    step(I_ADDU, 1, 0, mk(1, BR_PC4, 0,  1, 2, ALU_ADD,  0, 0, 0, 0,     0, 0, 0));
    step(I_ADDU, 0, 0, mk(0, BR_PC4, 0,  0, 0, 0,        1, 1, 0, DM_W,  0, 0, 0));
    step(I_NOP,  0, 0, mk(0, BR_PC4, 0,  2, 1, ALU_ADD,  0, 0, 0, 0,     1, 1, WDSEL_DM));
    step(I_ORI3, 1, 0, mk(0, BR_PC4, 0,  0, 0, 0,        2, 0, 0, 0,     0, 0, 0));
    step(I_NOP,  0, 0, mk(0, BR_PC4, 0,  0, 0, 0,        0, 0, 0, 0,     2, 1, WDSEL_ALU));
    step(I_NOP,  0, 0, mk(0, BR_PC4, 0,  0, 0, 0,        0, 0, 0, 0,     0, 0, 0));

    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
    #1;
    n_checks++;
    if (sb_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
